lsu_mem_sequencer: RTL and testbench

Load/store sequencer inside the LSU. Accepts one warp-wide memory instruction per handshake: 8 per-lane addresses from the AGU plus a lane mask. Serialises those accesses onto the single-ported data-memory interface, one outstanding access at a time, and gathers load data into one 8-lane result. Returns that result to the warp scheduler/writeback with a valid/ready handshake.

---
 rtl/lsu_mem_sequencer_pkg.sv | 19 +
 rtl/lsu_mem_sequencer_if.sv | 47 ++++
 rtl/lsu_mem_sequencer_lane_select.sv | 20 ++
 rtl/lsu_mem_sequencer.sv | 161 ++++++++++++++++
 tb/tb_lsu_mem_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_sequencer_pkg.sv
// Shared types and sizes for the LSU load/store sequencer.
package lsu_pkg;
  localparam int NUM_LANES  = 8;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 8;
  localparam int LANE_IDX_W = $clog2(NUM_LANES);

  typedef logic [NUM_LANES-1:0]                 lane_mask_t;
  typedef logic [LANE_IDX_W-1:0]                lane_idx_t;
  typedef logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] lane_addr_vec_t;
  typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_data_vec_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_seq_state_t;
endpackage

// File: rtl/lsu_mem_sequencer_if.sv
// Request, data-memory and completion signals of the LSU sequencer.
// master = the sequencer, slave = the AGU / memory / writeback side.
interface lsu_mem_sequencer_if #(
  parameter int DATA_WIDTH = lsu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = lsu_pkg::ADDR_WIDTH,
  parameter int NUM_LANES  = lsu_pkg::NUM_LANES
);
  logic                                 req_valid;
  logic                                 req_ready;
  logic                                 req_is_store;
  logic [1:0]                           req_warp;
  logic [NUM_LANES-1:0]                 req_mask;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] req_wdata;

  logic                                 mem_req_valid;
  logic                                 mem_req_ready;
  logic                                 mem_we;
  logic [ADDR_WIDTH-1:0]                mem_addr;
  logic [DATA_WIDTH-1:0]                mem_wdata;
  logic                                 mem_rsp_valid;
  logic [DATA_WIDTH-1:0]                mem_rdata;

  logic                                 done_valid;
  logic                                 done_ready;
  logic [1:0]                           done_warp;
  logic [NUM_LANES-1:0]                 done_mask;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] done_data;

  modport master (
    input  req_valid, req_is_store, req_warp, req_mask, req_addr, req_wdata,
    output req_ready,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output done_valid, done_warp, done_mask, done_data,
    input  done_ready
  );

  modport slave (
    output req_valid, req_is_store, req_warp, req_mask, req_addr, req_wdata,
    input  req_ready,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  done_valid, done_warp, done_mask, done_data,
    output done_ready
  );
endinterface

// File: rtl/lsu_mem_sequencer_lane_select.sv
// Priority encoder: lowest pending lane and an any-pending flag.
module lane_select
  import lsu_pkg::*;
(
  input  lane_mask_t pending,
  output lane_idx_t  ptr,
  output logic       any_pending
);
  always_comb begin
    ptr         = '0;
    any_pending = 1'b0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        ptr         = lane_idx_t'(i);
        any_pending = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lsu_mem_sequencer.sv
// LSU sequencer: serialises a warp-wide load/store onto one memory port, gathers loads.
// Optional LSU_COALESCE_EN: a load lane repeating the last responded address reuses its data.
module lsu_mem_sequencer #(
  parameter int DATA_WIDTH = lsu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = lsu_pkg::ADDR_WIDTH,
  parameter int NUM_LANES  = lsu_pkg::NUM_LANES
) (
  input  logic                clk,
  input  logic                reset,
  lsu_mem_sequencer_if.master bus
);
  import lsu_pkg::*;

  // state    | meaning
  // IDLE     | req_ready high, waiting for an instruction
  // ISSUE    | presenting the lowest pending lane to memory
  // WAIT_RSP | load accepted, waiting for its read data
  // DONE     | completion offered until done_ready
  lsu_seq_state_t                       state;
  logic                                 is_store;
  logic [1:0]                           warp;
  lane_mask_t                           mask;
  lane_mask_t                           pending;
  lane_mask_t                           ptr_bit;
  lane_mask_t                           pending_next;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wdata_q;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] data_q;
  logic                                 req_ready_q;
  logic                                 done_valid_q;
  logic                                 any_pending;
  logic                                 last_lane;
  lane_idx_t                            ptr;

  lane_select u_lane_select (
    .pending     (pending),
    .ptr         (ptr),
    .any_pending (any_pending)
  );

  assign ptr_bit      = lane_mask_t'(1) << ptr;
  assign pending_next = pending & ~ptr_bit;
  assign last_lane    = (pending_next == '0);

`ifdef LSU_COALESCE_EN
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] last_data;
  logic                  last_hit;
  logic                  coal_hit;

  assign coal_hit          = (state == ISSUE) && !is_store && last_hit && (addr_q[ptr] == last_addr);
  assign bus.mem_req_valid = (state == ISSUE) && any_pending && !coal_hit;
`else
  assign bus.mem_req_valid = (state == ISSUE) && any_pending;
`endif

  assign bus.req_ready  = req_ready_q;
  assign bus.done_valid = done_valid_q;
  assign bus.mem_we     = is_store;
  assign bus.mem_addr   = addr_q[ptr];
  assign bus.mem_wdata  = wdata_q[ptr];
  assign bus.done_warp  = warp;
  assign bus.done_mask  = mask;
  assign bus.done_data  = data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      is_store     <= 1'b0;
      warp         <= '0;
      mask         <= '0;
      pending      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_q       <= '0;
      req_ready_q  <= 1'b1;
      done_valid_q <= 1'b0;
`ifdef LSU_COALESCE_EN
      last_addr    <= '0;
      last_data    <= '0;
      last_hit     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            is_store    <= bus.req_is_store;
            warp        <= bus.req_warp;
            mask        <= bus.req_mask;
            pending     <= bus.req_mask;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            data_q      <= '0;
            req_ready_q <= 1'b0;
`ifdef LSU_COALESCE_EN
            last_hit    <= 1'b0;
`endif
            if (bus.req_mask == '0) begin
              state        <= DONE;
              done_valid_q <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
`ifdef LSU_COALESCE_EN
          if (coal_hit) begin
            data_q[ptr] <= last_data;
            pending     <= pending_next;
            if (last_lane) begin
              state        <= DONE;
              done_valid_q <= 1'b1;
            end
          end else
`endif
          if (bus.mem_req_ready) begin
`ifdef LSU_COALESCE_EN
            last_hit <= 1'b0;
`endif
            if (is_store) begin
              pending <= pending_next;
              if (last_lane) begin
                state        <= DONE;
                done_valid_q <= 1'b1;
              end
            end else begin
              state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (bus.mem_rsp_valid) begin
            data_q[ptr] <= bus.mem_rdata;
            pending     <= pending_next;
`ifdef LSU_COALESCE_EN
            last_addr   <= addr_q[ptr];
            last_data   <= bus.mem_rdata;
            last_hit    <= 1'b1;
`endif
            if (last_lane) begin
              state        <= DONE;
              done_valid_q <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          if (bus.done_ready) begin
            state        <= IDLE;
            data_q       <= '0;
            done_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Self-checking bench for lsu_mem_sequencer: access-list/result model plus literal pins.
module tb_lsu_mem_sequencer;
  import lsu_pkg::*;

`ifdef LSU_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  lsu_mem_sequencer_if bus ();

  lsu_mem_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic        busy = 1'b0;
  logic        auto_rsp = 1'b1;
  logic        inject = 1'b0;
  logic [15:0] inject_data = '0;
  int          stall_req = 0;
  int          stall_idx = 0;

  // Expected memory accesses of the current instruction, in issue order.
  logic        exp_we   [8];
  logic [7:0]  exp_addr [8];
  logic [15:0] exp_wd   [8];
  int          exp_n = 0;

  // Owned by the monitor.
  int          acc_count = 0;
  int          stall_used = 0;
  logic        rsp_due = 1'b0;
  logic [7:0]  rsp_addr = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory: read data = 0x100 + address, one cycle after accept; optional stall.
  always @(posedge clk) begin
    #1;
    bus.mem_req_ready = !((stall_used < stall_req) && (acc_count == stall_idx));
    bus.mem_rsp_valid = (rsp_due && auto_rsp) || inject;
    bus.mem_rdata     = inject ? inject_data : (16'h0100 + {8'h00, rsp_addr});
  end

  always @(negedge clk) begin
    rsp_due = 1'b0;
    if (reset === 1'b1) begin
      if (bus.req_valid && bus.req_ready) begin
        acc_count  = 0;
        stall_used = 0;
      end
      if (!busy) begin
        check("idle_req_ready", bus.req_ready, 1'b1);
        check("idle_mem_req_valid", bus.mem_req_valid, 1'b0);
        check("idle_done_valid", bus.done_valid, 1'b0);
      end else begin
        check("busy_req_ready", bus.req_ready, 1'b0);
      end
      if (bus.mem_req_valid) begin
        check("mem_access_in_range", acc_count < exp_n, 1'b1);
        if (acc_count < exp_n) begin
          check("mem_we", bus.mem_we, exp_we[acc_count]);
          check("mem_addr", bus.mem_addr, exp_addr[acc_count]);
          check("mem_wdata", bus.mem_wdata, exp_wd[acc_count]);
        end
        if (bus.mem_req_ready) begin
          rsp_due  = !bus.mem_we;
          rsp_addr = bus.mem_addr;
          acc_count++;
        end else begin
          stall_used++;
        end
      end
      if (bus.done_valid) check("done_after_all_accesses", acc_count, exp_n);
    end
  end

  task automatic run_instr(input string name, input logic st, input logic [1:0] warp,
                           input logic [7:0] mask, input logic [7:0][7:0] addr,
                           input logic [7:0][15:0] wd, input int s_idx, input int s_cnt,
                           input int hold, output int got_cyc, output logic [127:0] got_data);
    logic [7:0][15:0] exp_data;
    int               exp_cyc;
    logic             have_last;
    logic [7:0]       last_a;
    exp_data  = '0;
    exp_cyc   = 1;
    have_last = 1'b0;
    last_a    = '0;
    exp_n     = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        if (st) begin
          exp_we[exp_n] = 1'b1; exp_addr[exp_n] = addr[i]; exp_wd[exp_n] = wd[i];
          exp_n++;
          exp_cyc += 1;
        end else begin
          exp_data[i] = 16'h0100 + {8'h00, addr[i]};
          if (COAL && have_last && addr[i] == last_a) begin
            exp_cyc += 1;
          end else begin
            exp_we[exp_n] = 1'b0; exp_addr[exp_n] = addr[i]; exp_wd[exp_n] = wd[i];
            exp_n++;
            exp_cyc  += 2;
            have_last = 1'b1;
            last_a    = addr[i];
          end
        end
      end
    end
    if (s_cnt > 0 && s_idx < exp_n) exp_cyc += s_cnt;
    stall_idx = s_idx;
    stall_req = s_cnt;

    @(posedge clk); #1;
    bus.req_is_store = st;
    bus.req_warp     = warp;
    bus.req_mask     = mask;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    busy          = 1'b1;
    got_cyc       = 1;
    check({name, "_first_issue"}, bus.mem_req_valid, mask != 8'h00);
    while (!bus.done_valid && got_cyc < 300) begin
      @(posedge clk); #1;
      got_cyc++;
    end
    check({name, "_done_cycle"}, got_cyc, exp_cyc);
    for (int k = 0; k < hold; k++) begin
      check({name, "_hold_done_valid"}, bus.done_valid, 1'b1);
      check({name, "_hold_req_ready"}, bus.req_ready, 1'b0);
      @(posedge clk); #1;
    end
    check({name, "_done_valid"}, bus.done_valid, 1'b1);
    check({name, "_done_warp"}, bus.done_warp, warp);
    check({name, "_done_mask"}, bus.done_mask, mask);
    check({name, "_done_data"}, bus.done_data, exp_data);
    check({name, "_access_count"}, acc_count, exp_n);
    got_data        = bus.done_data;
    bus.done_ready  = 1'b1;
    @(posedge clk); #1;
    bus.done_ready = 1'b0;
    busy           = 1'b0;
    stall_req      = 0;
    check({name, "_post_done_valid"}, bus.done_valid, 1'b0);
    check({name, "_post_req_ready"}, bus.req_ready, 1'b1);
    check({name, "_post_done_data"}, bus.done_data, 128'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][7:0]  a;
    logic [7:0][15:0] w;
    logic [127:0]     d;
    int               cyc;

    reset            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_warp     = '0;
    bus.req_mask     = '0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.done_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 8'h00);
    check("rst_done_valid", bus.done_valid, 1'b0);
    check("rst_done_mask", bus.done_mask, 8'h00);
    check("rst_done_data", bus.done_data, 128'h0);
    @(negedge clk);
    reset = 1'b1;

    // Full-mask load, addresses 0..7.
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'(i);
      w[i] = 16'hA000 + 16'(i);
    end
    run_instr("load_ff", 1'b0, 2'd1, 8'hFF, a, w, 0, 0, 0, cyc, d);
    check("lit_load_ff_cycle", cyc, 17);
    for (int i = 0; i < 8; i++) check("lit_load_ff_lane", d[i*16 +: 16], 16'h0100 + 16'(i));

    // Sparse store.
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'h40 + 8'(i);
      w[i] = 16'h5000 + 16'(i * 17);
    end
    run_instr("store_a5", 1'b1, 2'd2, 8'b1010_0101, a, w, 0, 0, 0, cyc, d);
    check("lit_store_a5_cycle", cyc, 5);
    check("lit_store_a5_writes", acc_count, 4);
    check("lit_store_a5_data", d, 128'h0);

    // Empty mask with completion back-pressure.
    run_instr("mask0", 1'b0, 2'd3, 8'h00, a, w, 0, 0, 3, cyc, d);
    check("lit_mask0_cycle", cyc, 1);
    check("lit_mask0_accesses", acc_count, 0);

    // Load with a two-cycle memory stall on lane 3.
    for (int i = 0; i < 8; i++) a[i] = 8'h80 + 8'(i);
    run_instr("load_stall", 1'b0, 2'd0, 8'hFF, a, w, 3, 2, 1, cyc, d);
    check("lit_load_stall_cycle", cyc, 19);
    check("lit_load_stall_lane3", d[3*16 +: 16], 16'h0183);

    // Mixed mask with repeated addresses.
    a = '0;
    a[0] = 8'h10; a[3] = 8'h10; a[5] = 8'h30; a[6] = 8'h30;
    run_instr("load_mixed", 1'b0, 2'd2, 8'b0110_1001, a, w, 0, 0, 0, cyc, d);
    check("lit_load_mixed_cycle", cyc, COAL ? 7 : 9);
    check("lit_load_mixed_lane5", d[5*16 +: 16], 16'h0130);
    check("lit_load_mixed_lane1", d[1*16 +: 16], 16'h0000);

    // Reset while waiting for read data, then a late response.
    auto_rsp = 1'b0;
    exp_n = 1; exp_we[0] = 1'b0; exp_addr[0] = 8'h05; exp_wd[0] = 16'h0000;
    @(posedge clk); #1;
    bus.req_is_store = 1'b0;
    bus.req_warp     = 2'd1;
    bus.req_mask     = 8'h01;
    bus.req_addr     = {8{8'h05}};
    bus.req_wdata    = '0;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    busy          = 1'b1;
    check("rstmid_issue_valid", bus.mem_req_valid, 1'b1);
    @(posedge clk); #1;
    check("rstmid_wait_no_req", bus.mem_req_valid, 1'b0);
    reset = 1'b0;
    busy  = 1'b0;
    #1;
    check("rstmid_req_ready", bus.req_ready, 1'b1);
    check("rstmid_done_valid", bus.done_valid, 1'b0);
    check("rstmid_done_mask", bus.done_mask, 8'h00);
    @(negedge clk);
    reset       = 1'b1;
    inject_data = 16'hBEEF;
    inject      = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("late_rsp_req_ready", bus.req_ready, 1'b1);
    check("late_rsp_done_valid", bus.done_valid, 1'b0);
    check("late_rsp_done_data", bus.done_data, 128'h0);
    auto_rsp = 1'b1;

    // Every lane on the same address.
    a = {8{8'h20}};
    run_instr("load_same", 1'b0, 2'd3, 8'hFF, a, w, 0, 0, 0, cyc, d);
    check("lit_load_same_cycle", cyc, COAL ? 10 : 17);
    check("lit_load_same_reads", acc_count, COAL ? 1 : 8);
    for (int i = 0; i < 8; i++) check("lit_load_same_lane", d[i*16 +: 16], 16'h0120);

    // Full store right after a load: no stale load data.
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'hF0 + 8'(i);
      w[i] = 16'h1234 + 16'(i);
    end
    run_instr("store_ff", 1'b1, 2'd0, 8'hFF, a, w, 0, 0, 1, cyc, d);
    check("lit_store_ff_cycle", cyc, 9);
    check("lit_store_ff_data", d, 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
